// File: rtl/muldiv_sequencer_pkg.sv
// ============================================================================
//  Module  : muldiv_sequencer_pkg
//  Brief   : Shared op, FSM-state and funct encodings for the HI/LO mul/div unit.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package muldiv_sequencer_pkg;

    typedef enum logic [1:0] {
        MD_MULTU = 2'd0,
        MD_MULT  = 2'd1,
        MD_DIVU  = 2'd2,
        MD_DIV   = 2'd3
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_PREP = 2'd1,
        MD_ITER = 2'd2,
        MD_FIX  = 2'd3
    } md_state_e;

    // SPECIAL-opcode funct field values for the HI/LO instructions
    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    function automatic logic md_is_div(input md_op_e o);
        return (o == MD_DIVU) || (o == MD_DIV);
    endfunction

    function automatic logic md_is_signed(input md_op_e o);
        return (o == MD_MULT) || (o == MD_DIV);
    endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_step.sv
// ============================================================================
//  Module  : muldiv_step
//  Brief   : One radix-2 iteration: shift-add multiply or restoring divide.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic                 is_div_i,
    input  logic [2*WIDTH-1:0]   acc_i,
    input  logic [WIDTH-1:0]     opd_i,
    output logic [2*WIDTH-1:0]   acc_o
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_top;
    logic [WIDTH:0] w_diff;

    // Multiply keeps the multiplier in the low half and shifts the product down
    // into it; divide keeps the partial remainder high and quotient bits low.
    always_comb begin
        w_sum  = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opd_i} : '0);
        w_top  = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
        w_diff = w_top - {1'b0, opd_i};
        if (is_div_i) begin
            if (w_diff[WIDTH]) begin
                acc_o = {w_top[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
            end else begin
                acc_o = {w_diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
            end
        end else begin
            acc_o = {w_sum, acc_i[WIDTH-1:1]};
        end
    end

endmodule

`default_nettype wire

// File: rtl/muldiv_sequencer.sv
// ============================================================================
//  Module  : muldiv_sequencer
//  Brief   : Iterative MULT/MULTU/DIV/DIVU engine owning HI/LO, with MFHI/MFLO
//            stall. Optional macro MULDIV_EARLY_EXIT_EN ends a multiply early
//            once the remaining multiplier bits are all zero.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             flush,
    input  logic             hilo_rd,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_e          state_q;
    md_op_e             op_q;
    logic [WIDTH-1:0]   rs_q;
    logic [WIDTH-1:0]   rt_q;
    logic [WIDTH-1:0]   opd_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               neg_q;
    logic               negr_q;
    logic               dz_q;
    logic               done_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic               w_div;
    logic               w_signed;
    logic [WIDTH-1:0]   w_rs_mag;
    logic [WIDTH-1:0]   w_rt_mag;
    logic [2*WIDTH-1:0] w_step;
    logic [2*WIDTH-1:0] acc_d;
    logic               w_early;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .is_div_i (w_div),
        .acc_i    (acc_q),
        .opd_i    (opd_q),
        .acc_o    (w_step)
    );

`ifdef MULDIV_EARLY_EXIT_EN
    logic [WIDTH-1:0] mpl_q;

    // Shadow of the not-yet-consumed multiplier bits; bit 0 is consumed this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mpl_q <= '0;
        end else if (state_q == MD_PREP) begin
            mpl_q <= w_rt_mag;
        end else if (state_q == MD_ITER) begin
            mpl_q <= mpl_q >> 1;
        end
    end

    always_comb begin
        w_early = !w_div && (mpl_q[WIDTH-1:1] == '0);
        acc_d   = w_early ? (w_step >> (cnt_q - CNT_W'(1))) : w_step;
    end
`else
    always_comb begin
        w_early = 1'b0;
        acc_d   = w_step;
    end
`endif

    always_comb begin
        w_div    = md_is_div(op_q);
        w_signed = md_is_signed(op_q);
        w_rs_mag = (w_signed && rs_q[WIDTH-1]) ? (~rs_q + 1'b1) : rs_q;
        w_rt_mag = (w_signed && rt_q[WIDTH-1]) ? (~rt_q + 1'b1) : rt_q;
        w_prod   = neg_q  ? (~acc_q + 1'b1) : acc_q;
        w_quo    = neg_q  ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
        w_rem    = negr_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MD_IDLE;
            op_q    <= MD_MULTU;
            rs_q    <= '0;
            rt_q    <= '0;
            opd_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            negr_q  <= 1'b0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done_q <= 1'b0;
            if (flush) begin
                state_q <= MD_IDLE;
            end else if (start) begin
                // A new request always replaces whatever is in flight.
                op_q    <= md_op_e'(op);
                rs_q    <= rs_val;
                rt_q    <= rt_val;
                state_q <= MD_PREP;
            end else begin
                case (state_q)
                    MD_PREP: begin
                        cnt_q  <= CNT_W'(WIDTH);
                        neg_q  <= w_signed && (rs_q[WIDTH-1] ^ rt_q[WIDTH-1]);
                        negr_q <= w_signed && rs_q[WIDTH-1];
                        dz_q   <= w_div && (rt_q == '0);
                        if (w_div) begin
                            opd_q <= w_rt_mag;
                            acc_q <= {{WIDTH{1'b0}}, w_rs_mag};
                        end else begin
                            opd_q <= w_rs_mag;
                            acc_q <= {{WIDTH{1'b0}}, w_rt_mag};
                        end
                        state_q <= (w_div && (rt_q == '0)) ? MD_FIX : MD_ITER;
                    end
                    MD_ITER: begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (w_early || (cnt_q == CNT_W'(1))) begin
                            state_q <= MD_FIX;
                        end
                    end
                    MD_FIX: begin
                        if (dz_q) begin
                            hi_q <= rs_q;
                            lo_q <= '1;
                        end else if (w_div) begin
                            hi_q <= w_rem;
                            lo_q <= w_quo;
                        end else begin
                            {hi_q, lo_q} <= w_prod;
                        end
                        done_q  <= 1'b1;
                        state_q <= MD_IDLE;
                    end
                    default: begin
                        state_q <= MD_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy  = (state_q != MD_IDLE);
    assign stall = hilo_rd & busy;
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
// ============================================================================
//  Module  : tb_muldiv_sequencer
//  Brief   : Directed scoreboard bench for the HI/LO multiply/divide sequencer.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_muldiv_sequencer;

    localparam int W = 32;

    logic         clk     = 1'b0;
    logic         rst_n   = 1'b0;
    logic         start   = 1'b0;
    logic [1:0]   op      = 2'd0;
    logic [W-1:0] rs_val  = '0;
    logic [W-1:0] rt_val  = '0;
    logic         flush   = 1'b0;
    logic         hilo_rd = 1'b0;
    logic         stall;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           cyc;
        string        name;
    } exp_t;

    exp_t sb[$];

    muldiv_sequencer #(
        .WIDTH (W),
        .CNT_W (6)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .flush   (flush),
        .hilo_rd (hilo_rd),
        .stall   (stall),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    exp_t e;
    always @(negedge clk) begin
        if (rst_n && done) begin
            chk("done_without_stall", {63'd0, stall}, 64'd0);
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
            end else begin
                e = sb.pop_front();
                chk({e.name, "_hi"},  {32'd0, hi}, {32'd0, e.hi});
                chk({e.name, "_lo"},  {32'd0, lo}, {32'd0, e.lo});
                chk({e.name, "_cyc"}, 64'(cyc),    64'(e.cyc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_cyc(input int target);
        while (cyc < target) tick();
    endtask

    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int t);
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        t      = cyc;
        tick();
        start  = 1'b0;
    endtask

    task automatic expect_res(input string name, input logic [W-1:0] ehi,
                              input logic [W-1:0] elo, input int ecyc);
        exp_t x;
        x.hi   = ehi;
        x.lo   = elo;
        x.cyc  = ecyc;
        x.name = name;
        sb.push_back(x);
    endtask

    task automatic drain(input string name);
        int k = 0;
        while (sb.size() != 0 && k < 100) begin
            tick();
            k++;
        end
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got %0d pending results expected 0", name, sb.size());
            sb.delete();
        end
        tick();
    endtask

    task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] ehi,
                          input logic [W-1:0] elo, input int lat);
        int t;
        issue(o, a, b, t);
        expect_res(name, ehi, elo, t + lat);
        drain(name);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish by 200000");
        $fatal(1);
    end

    initial begin
        int t;
        int t2;

        // Reset state, including stall held low in IDLE with hilo_rd high
        tick();
        tick();
        hilo_rd = 1'b1;
        #1;
        chk("rst_hi",    {32'd0, hi}, 64'd0);
        chk("rst_lo",    {32'd0, lo}, 64'd0);
        chk("rst_busy",  {63'd0, busy}, 64'd0);
        chk("rst_done",  {63'd0, done}, 64'd0);
        chk("rst_stall", {63'd0, stall}, 64'd0);
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        chk("idle_stall", {63'd0, stall}, 64'd0);
        hilo_rd = 1'b0;
        tick();

        // MULTU 6*7 with busy window checks
        issue(2'd0, 32'd6, 32'd7, t);
        expect_res("multu_6x7", 32'h0, 32'h2A, t + 35);
        @(negedge clk);
        chk("busy_T1", {63'd0, busy}, 64'd1);
        tick();
        goto_cyc(t + 34);
        @(negedge clk);
        chk("busy_T34", {63'd0, busy}, 64'd1);
        tick();
        @(negedge clk);
        chk("busy_T35", {63'd0, busy}, 64'd0);
        drain("multu_6x7");

        run_op("mult_m3x5",   2'd1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 35);
        run_op("div_m7d2",    2'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 35);
        run_op("div_7dm2",    2'd3, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 35);
        run_op("divu_by0",    2'd2, 32'h1234,     32'd0,        32'h1234,     32'hFFFFFFFF, 3);
        run_op("div_ovf",     2'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 35);

        // Flush at T+10: no done, HI/LO keep the overflow-case values
        issue(2'd2, 32'd100, 32'd7, t);
        goto_cyc(t + 10);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_busy", {63'd0, busy}, 64'd0);
        repeat (40) tick();
        chk("flush_hi", {32'd0, hi}, 64'd0);
        chk("flush_lo", {32'd0, lo}, 64'h80000000);

        // start + flush together: start is dropped
        start  = 1'b1;
        flush  = 1'b1;
        op     = 2'd0;
        rs_val = 32'd3;
        rt_val = 32'd3;
        tick();
        start = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        chk("start_flush_busy", {63'd0, busy}, 64'd0);
        repeat (40) tick();

        // Restart at T+4: only the second divide completes
        issue(2'd2, 32'd100, 32'd7, t);
        goto_cyc(t + 4);
        issue(2'd2, 32'd1000, 32'd9, t2);
        expect_res("restart", 32'd1, 32'd111, t + 39);
        drain("restart");

        // Stall window with hilo_rd held from T+5
        issue(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, t);
        expect_res("stall_multu", 32'hFFFFFFFE, 32'h00000001, t + 35);
        goto_cyc(t + 5);
        hilo_rd = 1'b1;
        while (cyc <= t + 35) begin
            @(negedge clk);
            chk($sformatf("stall_T%0d", cyc - t), {63'd0, stall}, (cyc <= t + 34) ? 64'd1 : 64'd0);
            tick();
        end
        hilo_rd = 1'b0;
        drain("stall_multu");

        // Asynchronous reset mid-DIV
        issue(2'd3, 32'hFFFFFF00, 32'd3, t);
        goto_cyc(t + 20);
        hilo_rd = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_hi",    {32'd0, hi}, 64'd0);
        chk("arst_lo",    {32'd0, lo}, 64'd0);
        chk("arst_busy",  {63'd0, busy}, 64'd0);
        chk("arst_stall", {63'd0, stall}, 64'd0);
        tick();
        tick();
        rst_n   = 1'b1;
        hilo_rd = 1'b0;
        tick();

        run_op("multu_2p16sq", 2'd0, 32'h00010000, 32'h00010000, 32'd1, 32'd0, 35);
        run_op("mult_m1xm1",   2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd1, 35);
        run_op("divu_100d7",   2'd2, 32'd100,      32'd7,        32'd2, 32'd14, 35);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
